// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver ends of the link.
//   tx_state_t      : TX FSM state encodings (IDLE/START/DATA/PARITY/STOP)
//   MIN_PRESCALE    : smallest usable CLK-cycles-per-bit ratio
//   PAR_EVEN/PAR_ODD: parity-type selector values
//   clamp_prescale(): maps a requested Prescale onto the usable range
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'b000,
        TX_START  = 3'b001,
        TX_DATA   = 3'b010,
        TX_PARITY = 3'b011,
        TX_STOP   = 3'b100
    } tx_state_t;

    localparam logic [5:0] MIN_PRESCALE = 6'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Ratios below the minimum leave too few samples per bit for the receiver's
    // mid-bit sampling, so they are raised to the minimum.
    function automatic logic [5:0] clamp_prescale(input logic [5:0] prescale);
        return (prescale < MIN_PRESCALE) ? MIN_PRESCALE : prescale;
    endfunction

endpackage

// File: rtl/uart_tx_parity.sv
// -----------------------------------------------------------------------------
// uart_tx_parity
// Combinational parity generator shared by the TX frame builder and the RX
// parity checker.
// Ports:
//   i_data     [DATA_WIDTH-1:0]  word whose parity is computed
//   i_par_typ                    PAR_EVEN or PAR_ODD
//   o_parity                     parity bit that makes the frame even/odd
// -----------------------------------------------------------------------------
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_parity
);

    logic w_xor;

    assign w_xor = ^i_data;

    // Even parity: the bit equals the XOR of the data so the total count of
    // ones is even. Odd parity inverts it.
    always_comb begin
        unique case (i_par_typ)
            PAR_EVEN: o_parity = w_xor;
            PAR_ODD:  o_parity = ~w_xor;
            default:  o_parity = w_xor;
        endcase
    end

endmodule

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// UART transmitter: serialises a parallel word into
//   start(0) | DATA_WIDTH data bits, LSB first | optional parity | stop(1)
// Every bit lasts Prescale CLK cycles (the same oversample ratio the receiver
// uses). Words are accepted through a DATA_VALID / BUSY handshake.
//
// Ports:
//   CLK         single clock, all logic on the rising edge
//   RST         synchronous, active-high reset; aborts any frame in flight
//   P_DATA      parallel word, latched when accepted
//   DATA_VALID  send request, sampled only while idle
//   PAR_EN      1: append a parity bit (latched at accept)
//   PAR_TYP     PAR_EVEN / PAR_ODD (latched at accept)
//   Prescale    CLK cycles per bit, values below MIN_PRESCALE act as MIN_PRESCALE
//   TX_OUT      registered serial line, idles high
//   BUSY        high for exactly the duration of the frame
//
// Build option:
//   UART_TX_STOP2_EN  defined   -> two stop bits (STOP lasts 2*Prescale cycles)
//                     undefined -> one stop bit
// -----------------------------------------------------------------------------
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int               BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    // Registered state and frame configuration.
    tx_state_t             r_state;
    logic [5:0]            r_edge_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [5:0]            r_prescale;
    logic                  r_tx_out;
    logic                  r_busy;

    // Next-state values.
    tx_state_t             w_state_next;
    logic [5:0]            w_edge_cnt_next;
    logic [BIT_W-1:0]      w_bit_cnt_next;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_par_en_next;
    logic                  w_par_typ_next;
    logic [5:0]            w_prescale_next;
    logic                  w_tx_out_next;
    logic                  w_busy_next;

    logic                  w_bit_done;
    logic                  w_parity;

    uart_tx_parity #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .i_data    (r_data),
        .i_par_typ (r_par_typ),
        .o_parity  (w_parity)
    );

    // Last CLK cycle of the current bit period.
    assign w_bit_done = (r_edge_cnt == (r_prescale - 6'd1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (RST) begin
            // NOTE: the latched word and config are reset along with the FSM;
            // they are few flops and this leaves no X on the parity path.
            r_state    <= TX_IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= PAR_EVEN;
            r_prescale <= MIN_PRESCALE;
            r_tx_out   <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_edge_cnt <= w_edge_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_data     <= w_data_next;
            r_par_en   <= w_par_en_next;
            r_par_typ  <= w_par_typ_next;
            r_prescale <= w_prescale_next;
            r_tx_out   <= w_tx_out_next;
            r_busy     <= w_busy_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        w_state_next    = r_state;
        w_edge_cnt_next = r_edge_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_data_next     = r_data;
        w_par_en_next   = r_par_en;
        w_par_typ_next  = r_par_typ;
        w_prescale_next = r_prescale;

        // The edge counter free-runs through each bit period in every bit state.
        if (r_state != TX_IDLE) begin
            w_edge_cnt_next = w_bit_done ? 6'd0 : (r_edge_cnt + 6'd1);
        end

        unique case (r_state)
            TX_IDLE: begin
                // Frame config is captured here and held for the whole frame,
                // so upstream changes mid-frame cannot disturb it.
                if (DATA_VALID) begin
                    w_state_next    = TX_START;
                    w_edge_cnt_next = 6'd0;
                    w_bit_cnt_next  = '0;
                    w_data_next     = P_DATA;
                    w_par_en_next   = PAR_EN;
                    w_par_typ_next  = PAR_TYP;
                    w_prescale_next = clamp_prescale(Prescale);
                end
            end

            TX_START: begin
                if (w_bit_done) begin
                    w_state_next = TX_DATA;
                end
            end

            TX_DATA: begin
                if (w_bit_done) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        // The bit counter leaves DATA cleared; it never counts
                        // past the last data bit.
                        w_bit_cnt_next = '0;
                        w_state_next   = r_par_en ? TX_PARITY : TX_STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
                    end
                end
            end

            TX_PARITY: begin
                if (w_bit_done) begin
                    w_state_next = TX_STOP;
                end
            end

            TX_STOP: begin
                if (w_bit_done) begin
`ifdef UART_TX_STOP2_EN
                    // The bit counter is idle in STOP, so it tracks which of
                    // the two stop bits is on the line.
                    if (r_bit_cnt == '0) begin
                        w_bit_cnt_next = BIT_W'(1);
                    end else begin
                        w_bit_cnt_next = '0;
                        w_state_next   = TX_IDLE;
                    end
`else
                    w_state_next = TX_IDLE;
`endif
                end
            end

            default: begin
                w_state_next    = TX_IDLE;
                w_edge_cnt_next = 6'd0;
                w_bit_cnt_next  = '0;
            end
        endcase

        // Outputs are decoded from the next state so that the registered line
        // and BUSY change on the same edge as the state itself: the start bit
        // appears on the cycle right after accept.
        w_busy_next = (w_state_next != TX_IDLE);

        unique case (w_state_next)
            TX_IDLE:   w_tx_out_next = 1'b1;
            TX_START:  w_tx_out_next = 1'b0;
            TX_DATA:   w_tx_out_next = r_data[w_bit_cnt_next];
            TX_PARITY: w_tx_out_next = w_parity;
            TX_STOP:   w_tx_out_next = 1'b1;
            default:   w_tx_out_next = 1'b1;
        endcase
    end

    assign TX_OUT = r_tx_out;
    assign BUSY   = r_busy;

endmodule

// File: tb/tb_uart_tx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_core
// Directed bench for uart_tx_core. Each accepted word is pushed into a
// scoreboard as a frame descriptor; the frame checker pops it and compares
// TX_OUT and BUSY on every cycle of the frame plus the idle cycle after it.
// -----------------------------------------------------------------------------
module tb_uart_tx_core;
    import uart_pkg::*;

    localparam int NONE = -10;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       BUSY;

    always #5 CLK = ~CLK;

    uart_tx_core #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        int         ps;
    } frame_t;

    frame_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int cyc, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    function automatic int eff_ps(input logic [5:0] p);
        return (p < 6'd4) ? 4 : int'(p);
    endfunction

    function automatic int frame_len(input frame_t f);
        int stop_bits;
        stop_bits = 1;
`ifdef UART_TX_STOP2_EN
        stop_bits = 2;
`endif
        return (1 + 8 + (f.par_en ? 1 : 0) + stop_bits) * f.ps;
    endfunction

    // Expected line level c cycles after the accepting edge.
    function automatic logic exp_line(input frame_t f, input int c);
        int idx;
        int ones;
        idx  = c / f.ps;
        ones = 0;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return f.data[idx-1];
        if (idx == 9 && f.par_en) begin
            for (int i = 0; i < 8; i++) ones += int'(f.data[i]);
            return ((ones % 2) == 1) ^ f.par_typ;
        end
        return 1'b1;
    endfunction

    // Drive a request at a falling edge and record the frame it should produce.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        frame_t f;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = ps;
        DATA_VALID = 1'b1;
        f.data     = d;
        f.par_en   = pe;
        f.par_typ  = pt;
        f.ps       = eff_ps(ps);
        sb.push_back(f);
    endtask

    // Check one frame cycle by cycle. disturb_at: cycle at which a competing
    // request and new inputs are driven; reset_at: cycle at which RST is raised;
    // hold_valid: leave DATA_VALID asserted through the frame.
    task automatic run_frame(input int disturb_at, input int reset_at, input bit hold_valid);
        frame_t f;
        int     len;
        check("sb_has_frame", 0, sb.size() > 0, 1'b1);
        if (sb.size() == 0) return;
        f   = sb.pop_front();
        len = frame_len(f);
        for (int c = 0; c < len; c++) begin
            @(negedge CLK);
            check("tx_out", c, TX_OUT, exp_line(f, c));
            check("busy", c, BUSY, 1'b1);
            if (c == 0 && !hold_valid) DATA_VALID = 1'b0;
            if (c == disturb_at) begin
                DATA_VALID = 1'b1;
                P_DATA     = 8'h3C;
                Prescale   = 6'd16;
                PAR_EN     = ~PAR_EN;
                PAR_TYP    = ~PAR_TYP;
            end
            if (c == disturb_at + 1) DATA_VALID = 1'b0;
            if (c == reset_at) begin
                RST = 1'b1;
                @(negedge CLK);
                check("rst_tx_out", c + 1, TX_OUT, 1'b1);
                check("rst_busy", c + 1, BUSY, 1'b0);
                RST        = 1'b0;
                DATA_VALID = 1'b0;
                return;
            end
        end
        @(negedge CLK);
        check("idle_busy", len, BUSY, 1'b0);
        check("idle_tx_out", len, TX_OUT, 1'b1);
    endtask

    initial begin
        RST        = 1'b1;
        DATA_VALID = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = PAR_EVEN;
        Prescale   = 6'd8;

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset_tx_out", 0, TX_OUT, 1'b1);
        check("reset_busy", 0, BUSY, 1'b0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_tx_out0", 0, TX_OUT, 1'b1);
        check("idle_busy0", 0, BUSY, 1'b0);

        // Even parity, 0xA5, 8 cycles per bit: 88-cycle frame
        send(8'hA5, 1'b1, PAR_EVEN, 6'd8);
        run_frame(NONE, NONE, 1'b0);

        // Odd parity, 0x01, 16 cycles per bit: parity bit 0, 176-cycle frame
        send(8'h01, 1'b1, PAR_ODD, 6'd16);
        run_frame(NONE, NONE, 1'b0);

        // No parity, 0xFF: 80-cycle frame
        send(8'hFF, 1'b0, PAR_EVEN, 6'd8);
        run_frame(NONE, NONE, 1'b0);

        // Competing request and input changes mid-frame are ignored
        send(8'h55, 1'b0, PAR_EVEN, 6'd8);
        run_frame(20, NONE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("dropped_busy", i, BUSY, 1'b0);
            check("dropped_tx_out", i, TX_OUT, 1'b1);
        end

        // Reset during DATA aborts the frame; the next request is clean
        send(8'h96, 1'b1, PAR_EVEN, 6'd8);
        run_frame(NONE, 30, 1'b0);
        send(8'h3A, 1'b1, PAR_ODD, 6'd6);
        run_frame(NONE, NONE, 1'b0);

        // Prescale below the minimum behaves as 4 cycles per bit
        send(8'hC3, 1'b0, PAR_EVEN, 6'd2);
        run_frame(NONE, NONE, 1'b0);
        send(8'h5A, 1'b1, PAR_ODD, 6'd0);
        run_frame(NONE, NONE, 1'b0);

        // Request held high across frames: one idle cycle, then the next frame
        send(8'h81, 1'b1, PAR_EVEN, 6'd5);
        run_frame(NONE, NONE, 1'b1);
        send(8'h81, 1'b1, PAR_EVEN, 6'd5);
        run_frame(NONE, NONE, 1'b0);

        // Largest Prescale
        send(8'h80, 1'b1, PAR_EVEN, 6'd63);
        run_frame(NONE, NONE, 1'b0);

        check("sb_empty", 0, sb.size() == 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
